// File: rtl/read_descriptor_sequencer_pkg.sv
// Shared definitions for the read descriptor sequencer: FSM state encoding
// and the packing layout of a queued descriptor {base | length | fixed | tag}.
package read_descriptor_sequencer_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  function automatic int desc_width(int aw, int tw);
    return 2 * aw + 1 + tw;
  endfunction

  function automatic int fixed_bit(int tw);
    return tw;
  endfunction

  function automatic int length_lsb(int tw);
    return tw + 1;
  endfunction

  function automatic int base_lsb(int aw, int tw);
    return tw + 1 + aw;
  endfunction

endpackage

// File: rtl/read_descriptor_sequencer_if.sv
// Descriptor, read-master control and status signals of the sequencer.
// The sequencer uses the master modport; its environment uses slave.
interface read_descriptor_sequencer_if #(
  parameter int ADDRESSWIDTH = 24,
  parameter int TAGWIDTH     = 8
);

  logic                    desc_valid;
  logic                    desc_ready;
  logic [ADDRESSWIDTH-1:0] desc_base;
  logic [ADDRESSWIDTH-1:0] desc_length;
  logic                    desc_fixed_location;
  logic [TAGWIDTH-1:0]     desc_tag;

  logic                    control_go;
  logic [ADDRESSWIDTH-1:0] control_read_base;
  logic [ADDRESSWIDTH-1:0] control_read_length;
  logic                    control_fixed_location;
  logic                    control_done;

  logic                    status_busy;
  logic                    status_complete;
  logic                    status_error;
  logic [TAGWIDTH-1:0]     status_tag;

  modport master (
    input  desc_valid, desc_base, desc_length, desc_fixed_location, desc_tag,
    input  control_done,
    output desc_ready,
    output control_go, control_read_base, control_read_length, control_fixed_location,
    output status_busy, status_complete, status_error, status_tag
  );

  modport slave (
    output desc_valid, desc_base, desc_length, desc_fixed_location, desc_tag,
    output control_done,
    input  desc_ready,
    input  control_go, control_read_base, control_read_length, control_fixed_location,
    input  status_busy, status_complete, status_error, status_tag
  );

endinterface

// File: rtl/read_descriptor_sequencer_desc_fifo.sv
// Register FIFO with full/empty flags and show-ahead read data.
// DEPTH must be a power of two so the pointers wrap naturally.
module desc_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push_ok;
  logic                  pop_ok;

  assign full_o     = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/read_descriptor_sequencer.sv
// Queues read descriptors, splits each into MAXCHUNK-sized read-master
// commands, waits for control_done per chunk and reports one completion.
//
// state  | meaning
// IDLE   | waiting for a queued descriptor; pops it into working registers
// LOAD   | validate, register chunk base/length/fixed for the read master
// ISSUE  | control_go pulse
// SETTLE | dead cycle while the read master's done flag is stale
// WAIT   | wait for control_done, advance address and remaining length
// DONE   | completion pulse with tag and error
module read_descriptor_sequencer
  import read_descriptor_sequencer_pkg::*;
#(
  parameter int ADDRESSWIDTH    = 24,
  parameter int BYTEENABLEWIDTH = 2,
  parameter int MAXCHUNK        = 256,
  parameter int DESCDEPTH       = 4,
  parameter int DESCDEPTH_LOG2  = 2,
  parameter int TAGWIDTH        = 8
) (
  input logic                         clk,
  input logic                         reset_n,
  read_descriptor_sequencer_if.master bus
);

  localparam int DW     = desc_width(ADDRESSWIDTH, TAGWIDTH);
  localparam int FIX_B  = fixed_bit(TAGWIDTH);
  localparam int LEN_L  = length_lsb(TAGWIDTH);
  localparam int BASE_L = base_lsb(ADDRESSWIDTH, TAGWIDTH);

  localparam logic [ADDRESSWIDTH-1:0] MAXCHUNK_W = ADDRESSWIDTH'(MAXCHUNK);
  localparam logic [ADDRESSWIDTH-1:0] BEW_W      = ADDRESSWIDTH'(BYTEENABLEWIDTH);

  logic                    ready_en_q;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [DW-1:0]           fifo_din;
  logic [DW-1:0]           fifo_dout;

  logic [2:0]              state_q, state_d;
  logic [ADDRESSWIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDRESSWIDTH-1:0] remaining_q, remaining_d;
  logic                    fixed_q, fixed_d;
  logic [TAGWIDTH-1:0]     tag_q, tag_d;
  logic                    error_q, error_d;
  logic [ADDRESSWIDTH-1:0] rd_base_q, rd_base_d;
  logic [ADDRESSWIDTH-1:0] rd_len_q, rd_len_d;
  logic                    rd_fixed_q, rd_fixed_d;

  logic [ADDRESSWIDTH-1:0] chunk;
  logic                    bad_desc;

  // desc_ready stays low through reset and comes up on the first clock after.
  assign bus.desc_ready = ready_en_q & ~fifo_full;
  assign fifo_push      = bus.desc_valid & bus.desc_ready;
  assign fifo_pop       = (state_q == ST_IDLE) & ~fifo_empty;
  assign fifo_din       = {bus.desc_base, bus.desc_length, bus.desc_fixed_location, bus.desc_tag};

  desc_fifo #(
    .WIDTH      (DW),
    .DEPTH      (DESCDEPTH),
    .DEPTH_LOG2 (DESCDEPTH_LOG2)
  ) u_desc_fifo (
    .clk         (clk),
    .rst_n       (reset_n),
    .push_i      (fifo_push),
    .push_data_i (fifo_din),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_dout),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign chunk    = (remaining_q > MAXCHUNK_W) ? MAXCHUNK_W : remaining_q;
  assign bad_desc = (remaining_q == '0) ||
                    ((remaining_q % BEW_W) != '0) ||
                    ((cur_addr_q % BEW_W) != '0);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    fixed_d     = fixed_q;
    tag_d       = tag_q;
    error_d     = error_q;
    rd_base_d   = rd_base_q;
    rd_len_d    = rd_len_q;
    rd_fixed_d  = rd_fixed_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          cur_addr_d  = fifo_dout[BASE_L +: ADDRESSWIDTH];
          remaining_d = fifo_dout[LEN_L +: ADDRESSWIDTH];
          fixed_d     = fifo_dout[FIX_B];
          tag_d       = fifo_dout[TAGWIDTH-1:0];
          error_d     = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bad_desc) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          rd_base_d  = cur_addr_q;
          rd_len_d   = chunk;
          rd_fixed_d = fixed_q;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.control_done) begin
          remaining_d = remaining_q - rd_len_q;
          if (!fixed_q) cur_addr_d = cur_addr_q + rd_len_q;
          state_d = (remaining_q == rd_len_q) ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en_q  <= 1'b0;
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      fixed_q     <= 1'b0;
      tag_q       <= '0;
      error_q     <= 1'b0;
      rd_base_q   <= '0;
      rd_len_q    <= '0;
      rd_fixed_q  <= 1'b0;
    end else begin
      ready_en_q  <= 1'b1;
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      fixed_q     <= fixed_d;
      tag_q       <= tag_d;
      error_q     <= error_d;
      rd_base_q   <= rd_base_d;
      rd_len_q    <= rd_len_d;
      rd_fixed_q  <= rd_fixed_d;
    end
  end

  assign bus.control_go             = (state_q == ST_ISSUE);
  assign bus.control_read_base      = rd_base_q;
  assign bus.control_read_length    = rd_len_q;
  assign bus.control_fixed_location = rd_fixed_q;

  assign bus.status_busy     = (state_q != ST_IDLE);
  assign bus.status_complete = (state_q == ST_DONE);
  assign bus.status_error    = (state_q == ST_DONE) & error_q;
  assign bus.status_tag      = (state_q == ST_DONE) ? tag_q : '0;

endmodule

// File: tb/tb_read_descriptor_sequencer.sv
// Bench for read_descriptor_sequencer: directed and random descriptors checked
// against a chunking model, with a behavioural read master answering go pulses.
module tb_read_descriptor_sequencer;

  localparam int AW   = 24;
  localparam int TW   = 8;
  localparam int MAXC = 256;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    logic          fixed;
    int            cyc;
  } cmd_t;

  typedef struct {
    logic [TW-1:0] tag;
    logic          err;
  } comp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic rm_done = 1'b1;

  always #5 clk = ~clk;

  read_descriptor_sequencer_if #(.ADDRESSWIDTH(AW), .TAGWIDTH(TW)) bus ();

  read_descriptor_sequencer #(
    .ADDRESSWIDTH    (AW),
    .BYTEENABLEWIDTH (2),
    .MAXCHUNK        (MAXC),
    .DESCDEPTH       (4),
    .DESCDEPTH_LOG2  (2),
    .TAGWIDTH        (TW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.control_done = rm_done;

  cmd_t  exp_cmd[$];
  cmd_t  obs_cmd[$];
  comp_t exp_comp[$];
  comp_t obs_comp[$];

  int tests     = 0;
  int fails     = 0;
  int cyc       = 0;
  int early_evt = 0;
  int rm_phase  = 0;
  int rm_rem    = 0;
  bit rm_busy   = 0;

  // Read master stand-in: done stays high (stale) through the settle cycle,
  // then drops for 1..6 cycles. Any go/complete while it is busy is an error.
  always @(negedge clk) begin
    cmd_t  c;
    comp_t p;
    if (!reset_n) begin
      rm_done  = 1'b1;
      rm_busy  = 0;
      rm_phase = 0;
    end else begin
      cyc++;
      if ((bus.control_go || bus.status_complete) && rm_busy) early_evt++;
      if (bus.status_complete) begin
        p.tag = bus.status_tag;
        p.err = bus.status_error;
        obs_comp.push_back(p);
      end
      if (bus.control_go) begin
        c.base  = bus.control_read_base;
        c.len   = bus.control_read_length;
        c.fixed = bus.control_fixed_location;
        c.cyc   = cyc;
        obs_cmd.push_back(c);
        rm_busy  = 1;
        rm_phase = 1;
      end else if (rm_phase == 1) begin
        rm_phase = 2;
      end else if (rm_phase == 2) begin
        rm_done  = 1'b0;
        rm_rem   = $urandom_range(1, 6);
        rm_phase = 3;
      end else if (rm_phase == 3) begin
        rm_rem--;
        if (rm_rem == 0) begin
          rm_done  = 1'b1;
          rm_busy  = 0;
          rm_phase = 0;
        end
      end
    end
  end

  // Reference: a descriptor becomes a list of min(remaining, MAXC) chunks,
  // or none at all if it is empty or misaligned.
  function automatic void model_push(logic [AW-1:0] base, logic [AW-1:0] len,
                                     logic fixed, logic [TW-1:0] tag);
    longint rem, addr, ch;
    cmd_t   c;
    comp_t  p;
    bit     bad;
    bad  = (len == 0) || (len % 2 != 0) || (base % 2 != 0);
    rem  = longint'(len);
    addr = longint'(base);
    if (!bad) begin
      while (rem > 0) begin
        ch      = (rem > MAXC) ? MAXC : rem;
        c.base  = AW'(addr);
        c.len   = AW'(ch);
        c.fixed = fixed;
        c.cyc   = 0;
        exp_cmd.push_back(c);
        rem = rem - ch;
        if (!fixed) addr = (addr + ch) % (longint'(1) << AW);
      end
    end
    p.tag = tag;
    p.err = bad;
    exp_comp.push_back(p);
  endfunction

  task automatic clear_q();
    exp_cmd.delete();
    obs_cmd.delete();
    exp_comp.delete();
    obs_comp.delete();
    early_evt = 0;
  endtask

  task automatic send_desc(input logic [AW-1:0] base, input logic [AW-1:0] len,
                           input logic fixed, input logic [TW-1:0] tag);
    int g;
    g = 0;
    @(negedge clk);
    bus.desc_base           = base;
    bus.desc_length         = len;
    bus.desc_fixed_location = fixed;
    bus.desc_tag            = tag;
    bus.desc_valid          = 1'b1;
    while (bus.desc_ready !== 1'b1 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) begin
      tests++;
      fails++;
      $display("FAIL send_desc timeout: desc_ready %b required 1", bus.desc_ready);
      bus.desc_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_push(base, len, fixed, tag);
      #1 bus.desc_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(output bit ok);
    int g;
    g = 0;
    while ((obs_comp.size() < exp_comp.size() || bus.status_busy) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    ok = (g < 5000);
  endtask

  task automatic test_reset();
    logic [69:0] outs;
    @(negedge clk);
    outs = {bus.control_go, bus.control_read_base, bus.control_read_length,
            bus.control_fixed_location, bus.status_busy, bus.status_complete,
            bus.status_error, bus.status_tag, bus.desc_ready};
    tests++;
    if (outs !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    tests++;
    if (bus.desc_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_clock: got %b required 0", bus.desc_ready);
    end
    @(negedge clk);
    tests++;
    if (bus.desc_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_clock: got %b required 1", bus.desc_ready);
    end
    tests++;
    if (bus.status_busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_after_reset: got %b required 0", bus.status_busy);
    end
  endtask

  task automatic test_split();
    logic [AW-1:0] vb[3]    = '{24'h001000, 24'h002000, 24'hFFFF00};
    logic [AW-1:0] vl[3]    = '{24'd512, 24'd300, 24'd512};
    logic          vf[3]    = '{1'b0, 1'b1, 1'b0};
    logic [TW-1:0] vt[3]    = '{8'h11, 8'h22, 8'h33};
    logic [AW-1:0] eb[3][2] = '{'{24'h001000, 24'h001100},
                                '{24'h002000, 24'h002000},
                                '{24'hFFFF00, 24'h000000}};
    logic [AW-1:0] el[3][2] = '{'{24'd256, 24'd256}, '{24'd256, 24'd44}, '{24'd256, 24'd256}};
    bit ok;
    for (int v = 0; v < 3; v++) begin
      clear_q();
      send_desc(vb[v], vl[v], vf[v], vt[v]);
      wait_drain(ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL split%0d_drain: timed out, %0d completions required 1", v, obs_comp.size());
      end
      tests++;
      if (obs_cmd.size() != 2) begin
        fails++;
        $display("FAIL split%0d_go_count: got %0d required 2", v, obs_cmd.size());
      end
      for (int i = 0; i < 2 && i < obs_cmd.size(); i++) begin
        tests++;
        if ({obs_cmd[i].base, obs_cmd[i].len, obs_cmd[i].fixed} !== {eb[v][i], el[v][i], vf[v]}) begin
          fails++;
          $display("FAIL split%0d_chunk%0d: got %h/%0d/%b required %h/%0d/%b", v, i,
                   obs_cmd[i].base, obs_cmd[i].len, obs_cmd[i].fixed, eb[v][i], el[v][i], vf[v]);
        end
      end
      tests++;
      if (obs_comp.size() != 1 || obs_comp[0].tag !== vt[v] || obs_comp[0].err !== 1'b0) begin
        fails++;
        $display("FAIL split%0d_complete: got %0d pulses, tag %h err %b required 1 pulse tag %h err 0",
                 v, obs_comp.size(), (obs_comp.size() > 0) ? obs_comp[0].tag : 8'h0,
                 (obs_comp.size() > 0) ? obs_comp[0].err : 1'b0, vt[v]);
      end
    end
  endtask

  task automatic test_errors();
    logic [TW-1:0] et[3] = '{8'h44, 8'h55, 8'h66};
    bit ok;
    clear_q();
    send_desc(24'h003000, 24'd3, 1'b0, et[0]);
    send_desc(24'h003000, 24'd0, 1'b0, et[1]);
    send_desc(24'h003001, 24'd4, 1'b0, et[2]);
    wait_drain(ok);
    tests++;
    if (!ok || obs_comp.size() != 3) begin
      fails++;
      $display("FAIL err_count: got %0d completions required 3", obs_comp.size());
    end
    tests++;
    if (obs_cmd.size() != 0) begin
      fails++;
      $display("FAIL err_no_go: got %0d go pulses required 0", obs_cmd.size());
    end
    for (int i = 0; i < 3 && i < obs_comp.size(); i++) begin
      tests++;
      if (obs_comp[i].tag !== et[i] || obs_comp[i].err !== 1'b1) begin
        fails++;
        $display("FAIL err_complete%0d: got tag %h err %b required tag %h err 1",
                 i, obs_comp[i].tag, obs_comp[i].err, et[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int g;
    int n;
    clear_q();
    send_desc(24'h004000, 24'd1024, 1'b0, 8'hA0);
    g = 0;
    while (obs_cmd.size() == 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    tests++;
    if (obs_cmd.size() == 0) begin
      fails++;
      $display("FAIL b2b_first_go: got 0 go pulses required 1");
    end
    for (int i = 1; i <= 3; i++) send_desc(AW'(24'h010000 + i * 24'h100), 24'd64, 1'b0, TW'(8'hA0 + i));
    tests++;
    if (bus.desc_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_ready_3q: got %b required 1", bus.desc_ready);
    end
    send_desc(24'h010400, 24'd64, 1'b1, 8'hA4);
    tests++;
    if (bus.desc_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ready_4q: got %b required 0", bus.desc_ready);
    end
    send_desc(24'h010500, 24'd300, 1'b0, 8'hA5);
    wait_drain(ok);
    tests++;
    if (!ok || obs_comp.size() != exp_comp.size() || obs_cmd.size() != exp_cmd.size()) begin
      fails++;
      $display("FAIL b2b_counts: got %0d/%0d completions/chunks required %0d/%0d",
               obs_comp.size(), obs_cmd.size(), exp_comp.size(), exp_cmd.size());
    end
    n = (obs_comp.size() < exp_comp.size()) ? obs_comp.size() : exp_comp.size();
    for (int i = 0; i < n; i++) begin
      tests++;
      if (obs_comp[i].tag !== exp_comp[i].tag || obs_comp[i].err !== exp_comp[i].err) begin
        fails++;
        $display("FAIL b2b_complete%0d: got tag %h err %b required tag %h err %b", i,
                 obs_comp[i].tag, obs_comp[i].err, exp_comp[i].tag, exp_comp[i].err);
      end
    end
    n = (obs_cmd.size() < exp_cmd.size()) ? obs_cmd.size() : exp_cmd.size();
    for (int i = 0; i < n; i++) begin
      tests++;
      if ({obs_cmd[i].base, obs_cmd[i].len, obs_cmd[i].fixed} !==
          {exp_cmd[i].base, exp_cmd[i].len, exp_cmd[i].fixed}) begin
        fails++;
        $display("FAIL b2b_chunk%0d: got %h/%0d/%b required %h/%0d/%b", i,
                 obs_cmd[i].base, obs_cmd[i].len, obs_cmd[i].fixed,
                 exp_cmd[i].base, exp_cmd[i].len, exp_cmd[i].fixed);
      end
    end
  endtask

  task automatic test_random();
    bit            ok;
    int            n;
    int            r;
    int            mingap;
    int            bad_chunks;
    int            bad_comps;
    logic [AW-1:0] b;
    logic [AW-1:0] l;
    clear_q();
    for (int k = 0; k < 24; k++) begin
      b = AW'($urandom);
      if ($urandom_range(0, 4) != 0) b[0] = 1'b0;
      r = $urandom_range(0, 9);
      if (r == 0)      l = '0;
      else if (r == 1) l = AW'($urandom_range(1, 200) | 1);
      else             l = AW'($urandom_range(1, 450) * 2);
      send_desc(b, l, 1'($urandom_range(0, 1)), TW'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain(ok);
    tests++;
    if (!ok || obs_comp.size() != exp_comp.size() || obs_cmd.size() != exp_cmd.size()) begin
      fails++;
      $display("FAIL rand_counts: got %0d/%0d completions/chunks required %0d/%0d",
               obs_comp.size(), obs_cmd.size(), exp_comp.size(), exp_cmd.size());
    end
    bad_chunks = 0;
    n = (obs_cmd.size() < exp_cmd.size()) ? obs_cmd.size() : exp_cmd.size();
    for (int i = 0; i < n; i++) begin
      if ({obs_cmd[i].base, obs_cmd[i].len, obs_cmd[i].fixed} !==
          {exp_cmd[i].base, exp_cmd[i].len, exp_cmd[i].fixed}) begin
        if (bad_chunks < 4)
          $display("FAIL rand_chunk%0d: got %h/%0d/%b required %h/%0d/%b", i,
                   obs_cmd[i].base, obs_cmd[i].len, obs_cmd[i].fixed,
                   exp_cmd[i].base, exp_cmd[i].len, exp_cmd[i].fixed);
        bad_chunks++;
      end
    end
    tests++;
    if (bad_chunks != 0) fails++;
    bad_comps = 0;
    n = (obs_comp.size() < exp_comp.size()) ? obs_comp.size() : exp_comp.size();
    for (int i = 0; i < n; i++) begin
      if (obs_comp[i].tag !== exp_comp[i].tag || obs_comp[i].err !== exp_comp[i].err) begin
        if (bad_comps < 4)
          $display("FAIL rand_complete%0d: got tag %h err %b required tag %h err %b", i,
                   obs_comp[i].tag, obs_comp[i].err, exp_comp[i].tag, exp_comp[i].err);
        bad_comps++;
      end
    end
    tests++;
    if (bad_comps != 0) fails++;
    mingap = 1000;
    for (int i = 1; i < obs_cmd.size(); i++)
      if (obs_cmd[i].cyc - obs_cmd[i-1].cyc < mingap) mingap = obs_cmd[i].cyc - obs_cmd[i-1].cyc;
    tests++;
    if (mingap < 4) begin
      fails++;
      $display("FAIL rand_go_gap: got %0d cycles required >= 4", mingap);
    end
    tests++;
    if (early_evt != 0) begin
      fails++;
      $display("FAIL rand_done_wait: got %0d events before control_done required 0", early_evt);
    end
  endtask

  task automatic test_reset_mid();
    logic [69:0] outs;
    int g;
    bit busy_seen;
    clear_q();
    send_desc(24'h005000, 24'd512, 1'b0, 8'hB0);
    send_desc(24'h006000, 24'd64, 1'b0, 8'hB1);
    g = 0;
    while (rm_phase != 3 && g < 200) begin
      @(negedge clk);
      g++;
    end
    #2 reset_n = 1'b0;
    #1;
    outs = {bus.control_go, bus.control_read_base, bus.control_read_length,
            bus.control_fixed_location, bus.status_busy, bus.status_complete,
            bus.status_error, bus.status_tag, bus.desc_ready};
    tests++;
    if (outs !== '0 || g >= 200) begin
      fails++;
      $display("FAIL midreset_outputs: got %h required 0 (wait reached %0d)", outs, g);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.desc_ready !== 1'b1) begin
      fails++;
      $display("FAIL midreset_ready: got %b required 1", bus.desc_ready);
    end
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.status_busy) busy_seen = 1;
    end
    tests++;
    if (busy_seen || obs_cmd.size() != 1 || obs_comp.size() != 0) begin
      fails++;
      $display("FAIL midreset_abort: got busy %b, %0d go, %0d completions required 0, 1, 0",
               busy_seen, obs_cmd.size(), obs_comp.size());
    end
    clear_q();
  endtask

  initial begin
    bus.desc_valid          = 1'b0;
    bus.desc_base           = '0;
    bus.desc_length         = '0;
    bus.desc_fixed_location = 1'b0;
    bus.desc_tag            = '0;
    test_reset();
    test_split();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
